angle_bcd_mux: RTL

- Parametrised successor to the fixed four-channel angle-to-BCD display decoder.
- Selects one of NUM_CH binary angle channels with a one-hot select vector.
- Converts the selected value to DIGITS packed BCD digits using a sequential shift-add-3 (double-dabble) engine.
- Drives the seven-segment display path and holds the last good result; adds a busy/valid handshake, overflow saturation, select-error detection and an auto-refresh mode.

---
 rtl/angle_bcd_mux.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/angle_bcd_mux.sv
// angle_bcd_mux: selects one of NUM_CH binary angle channels with a one-hot
// select, converts it to DIGITS packed BCD digits with a sequential
// shift-add-3 engine and holds the last good result for the display path.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   angles_in    flattened channels, channel i = angles_in[i*IN_W +: IN_W]
//   sel          one-hot channel select
//   start        single-cycle convert request (dropped while busy)
//   auto_en      continuous re-conversion of the selected channel
//   bcd_out      packed BCD result, most significant digit in top nibble
//   ch_out       index of the channel that produced bcd_out
//   bcd_valid    one-cycle pulse when bcd_out/ch_out/ovf update
//   busy         conversion in progress
//   ovf          last result saturated to all nines
//   sel_err      one-cycle pulse when a triggered load finds sel not one-hot
module angle_bcd_mux #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*IN_W-1:0]    angles_in,
  input  logic [NUM_CH-1:0]         sel,
  input  logic                      start,
  input  logic                      auto_en,
  output logic [4*DIGITS-1:0]       bcd_out,
  output logic [$clog2(NUM_CH)-1:0] ch_out,
  output logic                      bcd_valid,
  output logic                      busy,
  output logic                      ovf,
  output logic                      sel_err
);

  localparam int unsigned CH_W    = $clog2(NUM_CH);
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned CNT_W   = $clog2(IN_W);
  localparam int unsigned MAX_VAL = (10 ** DIGITS) - 1;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_CH-1:0]    last_sel_q, last_sel_d;
  logic                 pending_q, pending_d;
  logic [IN_W-1:0]      val_q, val_d;
  logic [BCD_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CH_W-1:0]      idx_q, idx_d;
  logic                 sat_q, sat_d;
  logic [BCD_W-1:0]     bcd_out_q, bcd_out_d;
  logic [CH_W-1:0]      ch_out_q, ch_out_d;
  logic                 ovf_q, ovf_d;
  logic                 bcd_valid_q, bcd_valid_d;
  logic                 sel_err_q, sel_err_d;
  logic                 busy_q, busy_d;

  logic                 sel_onehot_c;
  logic [CH_W-1:0]      sel_idx_c;
  logic [IN_W-1:0]      sel_val_c;
  logic [BCD_W-1:0]     acc_adj_c;
  logic                 trigger_c;
  logic                 sel_moved_c;

  // Channel decode: one-hot test, index encode and AND-OR value mux.
  always_comb begin
    sel_onehot_c = (sel != '0) && ((sel & (sel - NUM_CH'(1))) == '0);
    sel_idx_c    = '0;
    sel_val_c    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel[i]) begin
        sel_idx_c = CH_W'(i);
      end
      sel_val_c = sel_val_c | (angles_in[i*IN_W +: IN_W] & {IN_W{sel[i]}});
    end
  end

  // Add-3 correction on every digit that would exceed 9 after doubling.
  always_comb begin
    acc_adj_c = acc_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) begin
        acc_adj_c[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
    end
  end

  assign trigger_c   = start || auto_en || (sel != last_sel_q) || pending_q;
  assign sel_moved_c = (sel != last_sel_q);

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    last_sel_d  = last_sel_q;
    pending_d   = pending_q;
    val_d       = val_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sat_d       = sat_q;
    bcd_out_d   = bcd_out_q;
    ch_out_d    = ch_out_q;
    ovf_d       = ovf_q;
    bcd_valid_d = 1'b0;
    sel_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trigger_c) begin
          pending_d = 1'b0;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        last_sel_d = sel;
        if (!sel_onehot_c) begin
          // Bad select: report it and keep the displayed result.
          sel_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          idx_d = sel_idx_c;
          if (32'(sel_val_c) > MAX_VAL) begin
            // Value cannot be shown: saturate to all nines, skip shifting.
            acc_d   = {DIGITS{4'h9}};
            sat_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            acc_d   = '0;
            val_d   = sel_val_c;
            cnt_d   = '0;
            sat_d   = 1'b0;
            state_d = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        // A select change during the conversion queues one re-conversion.
        if (sel_moved_c) begin
          pending_d = 1'b1;
        end
        acc_d = {acc_adj_c[BCD_W-2:0], val_q[IN_W-1]};
        val_d = {val_q[IN_W-2:0], 1'b0};
        if (cnt_q == LAST_SHIFT) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        if (sel_moved_c) begin
          pending_d = 1'b1;
        end
        bcd_out_d   = acc_q;
        ch_out_d    = idx_q;
        ovf_d       = sat_q;
        bcd_valid_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_sel_q  <= '0;
      pending_q   <= 1'b0;
      val_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      sat_q       <= 1'b0;
      bcd_out_q   <= '0;
      ch_out_q    <= '0;
      ovf_q       <= 1'b0;
      bcd_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_sel_q  <= last_sel_d;
      pending_q   <= pending_d;
      val_q       <= val_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sat_q       <= sat_d;
      bcd_out_q   <= bcd_out_d;
      ch_out_q    <= ch_out_d;
      ovf_q       <= ovf_d;
      bcd_valid_q <= bcd_valid_d;
      sel_err_q   <= sel_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bcd_out   = bcd_out_q;
  assign ch_out    = ch_out_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign sel_err   = sel_err_q;

endmodule
